motor_relu_seq: RTL and testbench
=================================

# motor_relu_seq

Time-multiplexed ReLU scheduler for the motor MPC network datapath. Accepts an `N_LANES`-wide vector of ap_fixed<32,8> activations under an ap_ctrl_hs-style start/done handshake and sequences the lanes one per cycle through a single shared activation lane unit. It collects the results in an output register bank and presents them as one vector. It sits between a dense layer and the next layer, replacing a fully parallel ReLU when area is tighter than latency.

## Interface
- `N_LANES`, default 4: vector length; must be ≥2.
- `DATA_W`, default 32: lane width, two's complement, 8 integer bits.
- `ap_clk`  in  1  clock; all logic rises on its positive edge.
- `ap_rst`  in  1  reset, synchronous, active-high.
- `ap_start`  in  1  request; sampled only in IDLE.
- `ap_ready`  out  1  inputs consumed this cycle; combinational, `(state==IDLE) && ap_start`.
- `ap_idle`  out  1  high in IDLE; combinational from state.
- `ap_done`  out  1  one-cycle pulse; `out_vec` is valid from this cycle.
- `in_vec`  in  N_LANES*DATA_W  input activations; lane i at bits [i*DATA_W +: DATA_W].
- `out_vec`  out  N_LANES*DATA_W  registered results, same lane packing.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on `ap_start`. At that edge, `in_vec` is latched into `in_buf` and `idx` is cleared to 0.
  - RUN: each cycle, `in_buf[idx]` passes through the lane unit and the result is written to `out_buf[idx]`. `idx` increments. Leave RUN at the edge that processes `idx == N_LANES-1`, entering DONE.
  - DONE → IDLE unconditionally. `ap_start` seen during RUN or DONE is ignored and not queued; the requester holds it until `ap_ready`.
- Lane function:
  - `y = ($signed(x) > 0) ? {1'b0, x[DATA_W-2:0]} : 0`.
  - Zero and negative values map to 0. The result is always non-negative.
- `out_vec` is driven straight from `out_buf`. It holds the last completed result until the next run overwrites it lane by lane; it is valid only from `ap_done` onward.
- `in_vec` may change freely after `ap_ready`.
- `idx` width is `$clog2(N_LANES)`. It never wraps inside a run; it is cleared on entry to RUN.

## Timing
- Reset values:
  - state = IDLE, so `ap_idle`=1 and `ap_ready`=0 unless `ap_start`.
  - `ap_done`=0, `idx`=0, `in_buf`=0, `out_buf`=0, so `out_vec`=0.
- Latency: if `ap_start` is sampled at edge E, `ap_done` is high in the cycle after edge E+N_LANES. That is 5 cycles for N_LANES=4.
- Initiation interval: N_LANES+2 cycles (IDLE, N_LANES×RUN, DONE).
- `ap_rst` mid-run aborts: no `ap_done`, `out_buf` is cleared, state returns to IDLE on that edge.
- `ap_rst` and `ap_start` in the same cycle: reset wins and nothing is latched.

## Configuration
- `MOTOR_RELU_CAP_EN` defined: the lane unit is a capped ReLU, `y = min(relu(x), RELU_CAP)`, where `RELU_CAP` = 6.0 = 32'h0600_0000. Inputs strictly greater than `RELU_CAP` output `RELU_CAP`; equality passes through.
- Not defined: plain ReLU as above. No cap logic is synthesized.

## Structure
- Shared package `motor_nn_pkg`:
  - `DATA_W`/`INT_W` constants and the fixed-point typedef `fix32_8_t`.
  - `RELU_CAP` constant.
  - FSM state enum `relu_seq_state_t`.
- One sub-module, `motor_relu_lane`: combinational single-lane ReLU (with the cap under the macro), instantiated once and shared.

## Test plan
- Reset, then idle: check `ap_idle`=1, `ap_done`=0, `out_vec`=0 for 10 cycles with `ap_start`=0.
- `in_vec` = {32'h0100_0000, 32'hFF00_0000, 32'h0, 32'h7FFF_FFFF} (lane0 first), pulse `ap_start`:
  - `ap_ready` is high in the start cycle.
  - `ap_done` is high exactly 5 cycles later.
  - `out_vec` lanes = {0100_0000, 0, 0, 7FFF_FFFF}; lane3 is 0600_0000 with `MOTOR_RELU_CAP_EN`.
- Hold `ap_start`=1 continuously: `ap_done` pulses every 6 cycles, and `ap_ready` fires only in IDLE.
- Change `in_vec` the cycle after `ap_ready`: results reflect the latched vector only.
- Assert `ap_rst` for one cycle in the 3rd RUN cycle: no `ap_done`, `out_vec`=0, `ap_idle`=1 the next cycle. A following run completes correctly.
- Cap boundary (macro on): lanes {0600_0000, 0600_0001, 8000_0000, 0000_0001} → {0600_0000, 0600_0000, 0, 0000_0001}.

Source files
------------

// File: rtl/motor_nn_pkg.sv
// Shared definitions for the motor MPC network datapath: fixed-point
// format constants, the ReLU cap value and the ReLU scheduler FSM states.
package motor_nn_pkg;

    localparam int DATA_W = 32;
    localparam int INT_W  = 8;

    // ap_fixed<32,8>: two's complement, 8 integer bits, 24 fraction bits
    typedef logic signed [DATA_W-1:0] fix32_8_t;

    // 6.0 in ap_fixed<32,8>
    localparam fix32_8_t RELU_CAP = 32'h0600_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } relu_seq_state_t;

endpackage

// File: rtl/motor_relu_lane.sv
// Single combinational ReLU lane shared by the motor_relu_seq scheduler.
// Optional feature macro: MOTOR_RELU_CAP_EN selects a ReLU capped at
// RELU_CAP (6.0); without it a plain ReLU is built with no cap logic.
module motor_relu_lane #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] x_i,
    output logic [DATA_W-1:0] y_o
);
    import motor_nn_pkg::*;

`ifdef MOTOR_RELU_CAP_EN
    localparam logic [DATA_W-1:0] CAP = DATA_W'(RELU_CAP);
`endif

    logic [DATA_W-1:0] relu;

    // Positive inputs pass (sign bit forced clear), zero and negatives go to 0;
    // with the cap enabled, anything strictly above the cap saturates to it.
    always_comb begin
        relu = ($signed(x_i) > 0) ? {1'b0, x_i[DATA_W-2:0]} : '0;
        y_o  = relu;
`ifdef MOTOR_RELU_CAP_EN
        if (relu > CAP) begin
            y_o = CAP;
        end
`endif
    end

endmodule

// File: rtl/motor_relu_seq.sv
// Time-multiplexed ReLU scheduler: latches an N_LANES vector on ap_start,
// pushes one lane per cycle through a shared motor_relu_lane and presents
// the collected results with an ap_done pulse (ap_ctrl_hs style).
// Optional feature macro: MOTOR_RELU_CAP_EN (capped ReLU in the lane unit).
module motor_relu_seq #(
    parameter int N_LANES = 4,
    parameter int DATA_W  = 32
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst,
    input  logic                      ap_start,
    output logic                      ap_ready,
    output logic                      ap_idle,
    output logic                      ap_done,
    input  logic [N_LANES*DATA_W-1:0] in_vec,
    output logic [N_LANES*DATA_W-1:0] out_vec
);
    import motor_nn_pkg::*;

    localparam int IDX_W = $clog2(N_LANES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_LANES - 1);

    relu_seq_state_t           state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [N_LANES*DATA_W-1:0] in_buf_q, in_buf_d;
    logic [N_LANES*DATA_W-1:0] out_buf_q, out_buf_d;
    logic [DATA_W-1:0]         lane_x;
    logic [DATA_W-1:0]         lane_y;

    assign lane_x = in_buf_q[idx_q*DATA_W +: DATA_W];

    motor_relu_lane #(
        .DATA_W(DATA_W)
    ) u_lane (
        .x_i(lane_x),
        .y_o(lane_y)
    );

    // State, lane index and both buffers; reset clears everything, which also
    // aborts a run in flight and blanks the result bank.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            in_buf_q  <= '0;
            out_buf_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            in_buf_q  <= in_buf_d;
            out_buf_q <= out_buf_d;
        end
    end

    // Next-state logic: latch on start, walk the lanes one per cycle, then
    // spend a single cycle in DONE before accepting the next request.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        in_buf_d  = in_buf_q;
        out_buf_d = out_buf_q;
        case (state_q)
            IDLE: begin
                if (ap_start) begin
                    state_d  = RUN;
                    idx_d    = '0;
                    in_buf_d = in_vec;
                end
            end
            RUN: begin
                out_buf_d[idx_q*DATA_W +: DATA_W] = lane_y;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake outputs decoded straight from the state register.
    always_comb begin
        ap_idle  = (state_q == IDLE);
        ap_ready = (state_q == IDLE) && ap_start;
        ap_done  = (state_q == DONE);
    end

    assign out_vec = out_buf_q;

endmodule

// File: tb/tb_motor_relu_seq.sv
// Scoreboard bench for motor_relu_seq (N_LANES=4, DATA_W=32). Expected
// vectors follow MOTOR_RELU_CAP_EN when the macro is defined for the build.
module tb_motor_relu_seq;

    localparam int N = 4;
    localparam int W = 32;

    typedef struct {
        logic [N*W-1:0] vec;
        int             cyc;
    } expItem_t;

    logic           ap_clk = 1'b0;
    logic           ap_rst = 1'b1;
    logic           ap_start = 1'b0;
    logic           ap_ready;
    logic           ap_idle;
    logic           ap_done;
    logic [N*W-1:0] in_vec = '0;
    logic [N*W-1:0] out_vec;

    int       cyc = 0;
    int       assertCount = 0;
    int       failCount = 0;
    expItem_t sbQ[$];

    // Lane 0 is the rightmost word in each concatenation.
    localparam logic [N*W-1:0] VEC_A = {32'h7FFF_FFFF, 32'h0000_0000, 32'hFF00_0000, 32'h0100_0000};
    localparam logic [N*W-1:0] VEC_B = {32'h0000_0001, 32'h8000_0000, 32'h0600_0001, 32'h0600_0000};
    localparam logic [N*W-1:0] VEC_C = {32'h8000_0000, 32'h1234_5678, 32'h0000_0002, 32'hFFFF_FFFF};
`ifdef MOTOR_RELU_CAP_EN
    localparam logic [N*W-1:0] EXP_A = {32'h0600_0000, 32'h0000_0000, 32'h0000_0000, 32'h0100_0000};
    localparam logic [N*W-1:0] EXP_B = {32'h0000_0001, 32'h0000_0000, 32'h0600_0000, 32'h0600_0000};
    localparam logic [N*W-1:0] EXP_C = {32'h0000_0000, 32'h0600_0000, 32'h0000_0002, 32'h0000_0000};
`else
    localparam logic [N*W-1:0] EXP_A = {32'h7FFF_FFFF, 32'h0000_0000, 32'h0000_0000, 32'h0100_0000};
    localparam logic [N*W-1:0] EXP_B = {32'h0000_0001, 32'h0000_0000, 32'h0600_0001, 32'h0600_0000};
    localparam logic [N*W-1:0] EXP_C = {32'h0000_0000, 32'h1234_5678, 32'h0000_0002, 32'h0000_0000};
`endif

    motor_relu_seq #(
        .N_LANES(N),
        .DATA_W(W)
    ) dut (
        .ap_clk(ap_clk),
        .ap_rst(ap_rst),
        .ap_start(ap_start),
        .ap_ready(ap_ready),
        .ap_idle(ap_idle),
        .ap_done(ap_done),
        .in_vec(in_vec),
        .out_vec(out_vec)
    );

    // 10 ns clock.
    always #5 ap_clk = ~ap_clk;

    // Cycle counter, stepped on every rising edge.
    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: whenever the DUT signals done, pop the oldest expectation and
    // compare both the result vector and the cycle it arrived in.
    always @(negedge ap_clk) begin
        if (!ap_rst && ap_done) begin
            if (sbQ.size() == 0) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL unexpected_done: got ap_done=1 expected no pending run (cycle %0d)", cyc);
            end else begin
                expItem_t e;
                e = sbQ.pop_front();
                checkOutput("done_cycle", cyc, e.cyc);
                checkOutput("out_vec", out_vec, e.vec);
            end
        end
    end

    // One start pulse; in_vec is scrambled right after ap_ready to prove only
    // the latched vector is used.
    task automatic applyStimulus(input logic [N*W-1:0] vec, input logic [N*W-1:0] exp);
        expItem_t e;
        @(posedge ap_clk);
        #1;
        ap_start = 1'b1;
        in_vec   = vec;
        e.vec = exp;
        e.cyc = cyc + 5;
        sbQ.push_back(e);
        @(negedge ap_clk);
        checkOutput("ap_ready_start", ap_ready, 1);
        @(posedge ap_clk);
        #1;
        ap_start = 1'b0;
        in_vec   = ~vec;
        repeat (6) @(posedge ap_clk);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #100000;
        failCount++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $fatal(1, "[TB] watchdog expired");
    end

    // Main directed sequence.
    initial begin
        int k;
        expItem_t e;

        repeat (3) @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge ap_clk);
            checkOutput("reset_idle", ap_idle, 1);
            checkOutput("reset_done", ap_done, 0);
            checkOutput("reset_ready", ap_ready, 0);
            checkOutput("reset_out_vec", out_vec, '0);
        end

        $display("[TB] basic vector");
        applyStimulus(VEC_A, EXP_A);
        $display("[TB] cap boundary vector");
        applyStimulus(VEC_B, EXP_B);
        applyStimulus(VEC_C, EXP_C);

        $display("[TB] ap_start held high");
        @(posedge ap_clk);
        #1;
        ap_start = 1'b1;
        in_vec   = VEC_A;
        k = cyc;
        for (int r = 0; r < 3; r++) begin
            e.vec = EXP_A;
            e.cyc = k + 5 + 6 * r;
            sbQ.push_back(e);
        end
        for (int i = 0; i < 18; i++) begin
            @(negedge ap_clk);
            checkOutput("held_ready", ap_ready, (i % 6 == 0) ? 1 : 0);
        end
        @(posedge ap_clk);
        #1;
        ap_start = 1'b0;
        repeat (4) @(posedge ap_clk);

        $display("[TB] reset during third RUN cycle");
        @(posedge ap_clk);
        #1;
        ap_start = 1'b1;
        in_vec   = VEC_C;
        @(posedge ap_clk);
        #1;
        ap_start = 1'b0;
        @(posedge ap_clk);
        #1;
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        @(negedge ap_clk);
        checkOutput("abort_idle", ap_idle, 1);
        checkOutput("abort_done", ap_done, 0);
        checkOutput("abort_out_vec", out_vec, '0);
        repeat (8) @(posedge ap_clk);

        $display("[TB] reset and start together");
        #1;
        ap_rst   = 1'b1;
        ap_start = 1'b1;
        in_vec   = VEC_A;
        @(posedge ap_clk);
        #1;
        ap_rst   = 1'b0;
        ap_start = 1'b0;
        @(negedge ap_clk);
        checkOutput("rst_start_idle", ap_idle, 1);
        repeat (8) @(negedge ap_clk);
        checkOutput("rst_start_out_vec", out_vec, '0);

        $display("[TB] run after abort");
        applyStimulus(VEC_B, EXP_B);

        repeat (10) @(posedge ap_clk);
        checkOutput("scoreboard_empty", sbQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
